instr_fetch_reader: RTL and testbench

- Read-side counterpart of the PC register: consumes the stored PC and fetches instructions from instruction memory.
- Issues in-order read requests over a valid/ready request channel and accepts fixed-order responses.
- Buffers fetched words in a small FIFO and presents {pc, instr} to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing buffered and in-flight fetches.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 52 +++++
 rtl/instr_fetch_reader.sv | 150 +++++++++++++++
 tb/tb_instr_fetch_reader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch reader.
package fetch_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  typedef enum logic {
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries.
// Flush wins over push/pop; head reads as zero while empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  entry_t                 wdata,
  input  logic                   pop,
  input  logic                   flush,
  output entry_t                 rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rdata = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_reader.sv
// Fetches instructions from the stored PC into a small output buffer.
// Optional macro FETCH_STATS_EN adds a saturating pop counter port.
module instr_fetch_reader #(
  parameter int ADDR_W     = fetch_pkg::ADDR_W,
  parameter int INSTR_W    = fetch_pkg::INSTR_W,
  parameter int FIFO_DEPTH = 2,
  parameter int PC_STEP    = fetch_pkg::PC_STEP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_req_addr,
  input  logic               mem_rsp_valid,
  input  logic [INSTR_W-1:0] mem_rsp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
`ifdef FETCH_STATS_EN
  output logic [ADDR_W-1:0]  out_pc,
  output logic [15:0]        fetch_count
`else
  output logic [ADDR_W-1:0]  out_pc
`endif
);

  import fetch_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_d;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     drop_d;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credit;
  logic              req_fire;
  logic              push_try;
  logic              push;
  logic              pop;
  logic              empty;
  logic              full;
  entry_t            wentry;
  entry_t            head;

  // Buffered plus in-flight words may never exceed the buffer size.
  assign credit = {1'b0, fifo_count} + {1'b0, outstanding};

  assign mem_req_valid = !reset
                       && (state_q == RUN)
                       && (credit < (CW+1)'(FIFO_DEPTH));
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign out_valid = !empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  assign pop      = out_valid && out_ready && !redirect_valid;
  assign push_try = mem_rsp_valid
                  && (drop_cnt == '0)
                  && !redirect_valid;
  assign push     = push_try && (!full || pop);

  assign wentry.pc    = rsp_pc;
  assign wentry.instr = mem_rsp_data;

  always_comb begin
    outstanding_d = outstanding
                  + CW'(req_fire)
                  - CW'(mem_rsp_valid);
    drop_d  = drop_cnt;
    state_d = state_q;
    if (redirect_valid) begin
      // Everything still in flight belongs to the old path.
      drop_d  = outstanding_d;
      state_d = (outstanding_d != '0) ? DRAIN : RUN;
    end else begin
      if (mem_rsp_valid && (drop_cnt != '0))
        drop_d = drop_cnt - 1'b1;
      if ((state_q == DRAIN) && (drop_d == '0))
        state_d = RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      fetch_pc    <= '0;
      rsp_pc      <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state_q     <= state_d;
      outstanding <= outstanding_d;
      drop_cnt    <= drop_d;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
      end else begin
        if (req_fire)
          fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        if (push)
          rsp_pc <= rsp_pc + ADDR_W'(PC_STEP);
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .flush (redirect_valid),
    .rdata (head),
    .count (fifo_count),
    .empty (empty),
    .full  (full)
  );

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fetch_count <= '0;
    else if (pop && (fetch_count != 16'hFFFF))
      fetch_count <= fetch_count + 16'd1;
  end
`endif

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    !(push_try && full && !pop)
  );

endmodule

// File: tb/tb_instr_fetch_reader.sv
// Directed bench for instr_fetch_reader with a sequence-level model.
module tb_instr_fetch_reader;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [7:0]  mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
`ifdef FETCH_STATS_EN
  logic [15:0] fetch_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic       hold;
  logic [7:0] mq[$];
  logic [7:0] req_log[$];
  logic [7:0] pop_log[$];
  logic [7:0] exp_req;
  logic [7:0] exp_out;

  instr_fetch_reader dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
`ifdef FETCH_STATS_EN
    .fetch_count    (fetch_count),
`endif
    .out_pc         (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [7:0] a);
    return {~a, 8'h5A, 8'hC3, a};
  endfunction

  function automatic logic [31:0] at(input logic [7:0] q[$], input int i);
    if (i < q.size()) return {24'h0, q[i]};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    ticks(2);
    hold = 1'b0;
    req_log.delete();
    pop_log.delete();
    reset = 1'b0;
  endtask

  // In-order memory: a request accepted at an edge answers one cycle
  // later unless hold stalls delivery.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) mq.delete();
      else if (mem_req_valid && mem_req_ready) mq.push_back(mem_req_addr);
      @(posedge clk);
      #1;
      if (!reset && !hold && mq.size() > 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = instr_of(mq.pop_front());
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
      end
    end
  end

  // Model: request and output streams are each a contiguous PC_STEP
  // sequence restarting at the redirect target (or 0 after reset).
  always @(negedge clk) begin
    if (reset) begin
      exp_req = 8'h00;
      exp_out = 8'h00;
    end else begin
      if (mem_req_valid && mem_req_ready) begin
        check("req_addr", {24'h0, mem_req_addr}, {24'h0, exp_req});
        if (!redirect_valid) req_log.push_back(mem_req_addr);
        exp_req = exp_req + 8'd4;
      end
      if (out_valid && out_ready && !redirect_valid) begin
        check("out_pc", {24'h0, out_pc}, {24'h0, exp_out});
        check("out_instr", out_instr, instr_of(exp_out));
        pop_log.push_back(out_pc);
        exp_out = exp_out + 8'd4;
      end
      if (redirect_valid) begin
        exp_req = redirect_pc;
        exp_out = redirect_pc;
      end
    end
  end

  task automatic wait_q(input int want, input string nm);
    int k;
    k = 0;
    while (mq.size() != want && k < 60) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (mq.size() != want) check(nm, mq.size(), want);
  endtask

  task automatic hold_then_redirect(input logic [7:0] pc);
    @(negedge clk);
    #1;
    hold = 1'b1;
    wait_q(2, "wait_two_outstanding");
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    req_log.delete();
    pop_log.delete();
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    mem_req_ready = 1'b1;
    out_ready = 1'b1;
    hold = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    #1 reset = 1'b1;
    #2;
    check("rst_req_valid", {31'h0, mem_req_valid}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_pc", {24'h0, out_pc}, 32'h0);

    // Streaming from reset.
    do_reset();
    ticks(15);
    check("s1_req0", at(req_log, 0), 32'h00);
    check("s1_req1", at(req_log, 1), 32'h04);
    check("s1_req2", at(req_log, 2), 32'h08);
    check("s1_pop0", at(pop_log, 0), 32'h00);
    check("s1_pop1", at(pop_log, 1), 32'h04);
    check("s1_rate", {31'h0, pop_log.size() >= 8}, 32'h1);

    // Back-pressure from decode.
    out_ready = 1'b0;
    do_reset();
    ticks(10);
    check("s2_nreq", req_log.size(), 2);
    check("s2_req_valid", {31'h0, mem_req_valid}, 32'h0);
    check("s2_out_valid", {31'h0, out_valid}, 32'h1);
    out_ready = 1'b1;
    ticks(6);
    check("s2_resume", at(req_log, 2), 32'h08);

    // Memory not ready: request held.
    mem_req_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s3_valid", {31'h0, mem_req_valid}, 32'h1);
      check("s3_addr", {24'h0, mem_req_addr}, 32'h00);
    end
    check("s3_nreq", req_log.size(), 0);
    mem_req_ready = 1'b1;
    ticks(8);
    check("s3_req0", at(req_log, 0), 32'h00);
    check("s3_req1", at(req_log, 1), 32'h04);

    // Redirect with 0x10 and 0x14 in flight.
    do_reset();
    begin
      int k;
      k = 0;
      while (!(mq.size() > 0 && mq[mq.size()-1] == 8'h10) && k < 60) begin
        @(negedge clk);
        #1;
        k++;
      end
      check("s4_saw_10", {31'h0, k < 60}, 32'h1);
    end
    hold = 1'b1;
    wait_q(2, "s4_wait_out");
    check("s4_pending0", at(mq, 0), 32'h10);
    check("s4_pending1", at(mq, 1), 32'h14);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    req_log.delete();
    pop_log.delete();
    tick();
    redirect_valid = 1'b0;
    check("s4_flushed", {31'h0, out_valid}, 32'h0);
    check("s4_drain", {31'h0, mem_req_valid}, 32'h0);
    @(negedge clk);
    #1;
    hold = 1'b0;
    ticks(12);
    check("s4_req0", at(req_log, 0), 32'h40);
    check("s4_pop0", at(pop_log, 0), 32'h40);

    // Redirect near the top of the address space.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 8'hF8;
    req_log.delete();
    pop_log.delete();
    tick();
    redirect_valid = 1'b0;
    ticks(14);
    check("s5_req0", at(req_log, 0), 32'hF8);
    check("s5_req1", at(req_log, 1), 32'hFC);
    check("s5_req2", at(req_log, 2), 32'h00);
    check("s5_pop0", at(pop_log, 0), 32'hF8);
    check("s5_pop1", at(pop_log, 1), 32'hFC);
    check("s5_pop2", at(pop_log, 2), 32'h00);

    // Reset while draining.
    hold_then_redirect(8'h80);
    check("s6_drain", {31'h0, mem_req_valid}, 32'h0);
    #3 reset = 1'b1;
    #1;
    check("s6_req_valid", {31'h0, mem_req_valid}, 32'h0);
    check("s6_out_valid", {31'h0, out_valid}, 32'h0);
    check("s6_out_instr", out_instr, 32'h0);
    check("s6_out_pc", {24'h0, out_pc}, 32'h0);
    do_reset();
    ticks(10);
    check("s6_req0", at(req_log, 0), 32'h00);
    check("s6_pop0", at(pop_log, 0), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
